lfsr_stream: RTL
================

Name: lfsr_stream

Overview:
- Parametrised XNOR Fibonacci LFSR pseudo-random source with a valid/ready stream output.
- Advances W steps per accepted word, so W new pseudo-random bits are produced per cycle at full throughput.
- Adds seed load, enable, lock-up protection and period-wrap detection.
- Feeds test-pattern, scrambler and BIST datapaths that need a backpressure-aware PRBS source.

Parameters:
- N, 32, LFSR length in bits; legal range 3..32, with any other value an elaboration error.
- W, 1, output word width and steps advanced per word; legal range 1..N, with any other value an elaboration error.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- load_i  input  1  load seed_i into state; highest priority.
- seed_i  input  N  seed value, sampled when load_i=1.
- en_i  input  1  generation enable.
- ready_i  input  1  downstream accepts data_o when valid_o=1.
- valid_o  output  1  data_o holds a valid word.
- data_o  output  W  output word.
- state_o  output  N  current LFSR state.
- lockup_o  output  1  one-cycle pulse: an all-ones seed was rejected.
- wrap_o  output  1  one-cycle pulse, coincident with a new word: the post-advance state equals the reference state.

Behaviour:
- Reset (async, rst_n_i=0):
  - state=0, reference state=0, data_o=0.
  - valid_o=0, lockup_o=0, wrap_o=0.
  - FSM=IDLE.
- Single step: t = XNOR of tap bits; state <= {state[N-2:0], t}.
- Tap sets (bit indices, XNOR-chained), fixed per N:
  - 3:{2,1} 4:{3,2} 5:{4,2} 6:{5,4} 7:{6,5}
  - 8:{7,5,4,3} 9:{8,4} 10:{9,6} 11:{10,8} 12:{11,5,3,0}
  - 13:{12,3,2,0} 14:{13,4,2,0} 15:{14,13} 16:{15,14,12,3} 17:{16,13}
  - 18:{17,10} 19:{18,5,1,0} 20:{19,16} 21:{20,18} 22:{21,20}
  - 23:{22,17} 24:{23,22,21,16} 25:{24,21} 26:{25,5,1,0} 27:{26,4,1,0}
  - 28:{27,24} 29:{28,26} 30:{29,5,3,0} 31:{30,27} 32:{31,21,1,0}
- Advance: W single steps applied combinationally within one cycle.
  - New data_o = post-advance state[W-1:0].
  - data_o[W-1] is the earliest generated bit; data_o[0] is the latest.
- Period: the sequence visits 2^N-1 states. All-ones is the XNOR lock-up state and is never reached from a legal state.
- FSM states:
  - IDLE: valid_o=0.
    - en_i=1 -> FILL.
  - FILL: one cycle; advance; data_o updates; valid_o<=1.
    - -> VALID.
  - VALID: valid_o=1.
    - ready_i=1 and en_i=1: advance, update data_o, stay VALID. Throughput is 1 word/cycle.
    - ready_i=1 and en_i=0: valid_o<=0, no advance -> IDLE.
    - ready_i=0: data_o, valid_o and state hold, regardless of en_i. Stream stability rule: valid_o never drops without a handshake except on load or reset.
- First valid word appears 2 cycles after en_i rises in IDLE.
- load_i=1 in any state:
  - state <= seed_i; reference state <= seed_i.
  - valid_o<=0; data_o holds; FSM -> IDLE.
  - Any pending word is discarded.
  - Overrides en_i and ready_i in the same cycle.
- Seed = all-ones: state and reference state are forced to 0 instead, and lockup_o pulses for 1 cycle after load.
- wrap_o: asserted in the same cycle data_o updates, when the post-advance state equals the reference state.
  - Only landing exactly on a word boundary is flagged; no intermediate-step detection.
- state_o = state register, unconditionally.
- Reset mid-stream: all outputs return to reset values asynchronously. No partial word is retained.

Test Plan:
- N=3, W=1, reset, en_i=1, ready_i=1:
  - state_o after each word: 001, 011, 110, 101, 010, 100, 000.
  - data_o: 1, 1, 0, 1, 0, 0, 0.
  - wrap_o=1 only on the 7th word.
  - First valid_o 2 cycles after en_i.
- N=3, W=3, reset, en_i=1, ready_i=1:
  - data_o words: 110, 100, 011, 010, 001, 101, 000.
  - wrap_o on the 7th word.
  - valid_o held high continuously.
- Backpressure, N=3, W=1: hold ready_i=0 for 5 cycles after the first valid word, toggling en_i.
  - data_o stays 1, valid_o stays 1, state_o stays 001.
  - Release ready_i -> next word 1 (state 011).
- Lock-up: N=3, load_i=1 with seed_i=111.
  - state_o=000, lockup_o pulses exactly 1 cycle, valid_o=0.
  - A subsequent run reproduces the first scenario.
- Seed and load priority: N=8, W=4, load seed 0x5A while in VALID with ready_i=1.
  - valid_o drops next cycle, state_o=0x5A.
  - Then compare 300 words against a software model.
  - wrap_o must fire exactly when the cumulative step count hits 255*k (every 255 words).
- N=32, W=32, reset mid-stream after 10 words:
  - valid_o=0, data_o=0 and state_o=0 immediately.
  - After release, the first 1000 words match the software model from state 0.

Source files
------------

// File: rtl/lfsr_stream_if.sv
// Stream bundle for lfsr_stream: control/seed inputs plus the word, state and status outputs.
interface lfsr_stream_if #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 1
);
  logic         load;
  logic [N-1:0] seed;
  logic         en;
  logic         ready;
  logic         valid;
  logic [W-1:0] data;
  logic [N-1:0] state;
  logic         lockup;
  logic         wrap;

  modport master (
    output load, seed, en, ready,
    input  valid, data, state, lockup, wrap
  );

  modport slave (
    input  load, seed, en, ready,
    output valid, data, state, lockup, wrap
  );
endinterface

// File: rtl/lfsr_stream.sv
// XNOR Fibonacci LFSR that advances W steps per accepted word and streams them over valid/ready,
// with seed load, all-ones lock-up rejection and period-wrap flagging.
module lfsr_stream #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 1
) (
  input logic          clk_i,
  input logic          rst_n_i,
  lfsr_stream_if.slave bus
);

  if (N < 3 || N > 32) begin : g_bad_n
    $error("lfsr_stream: N must be within 3..32");
  end
  if (W < 1 || W > N) begin : g_bad_w
    $error("lfsr_stream: W must be within 1..N");
  end

  function automatic logic [31:0] tap_bit(int unsigned i);
    return 32'(1) << i;
  endfunction

  function automatic logic [31:0] tap_mask(int unsigned n);
    logic [31:0] m;
    m = '0;
    case (n)
      3:  m = tap_bit(2)  | tap_bit(1);
      4:  m = tap_bit(3)  | tap_bit(2);
      5:  m = tap_bit(4)  | tap_bit(2);
      6:  m = tap_bit(5)  | tap_bit(4);
      7:  m = tap_bit(6)  | tap_bit(5);
      8:  m = tap_bit(7)  | tap_bit(5)  | tap_bit(4)  | tap_bit(3);
      9:  m = tap_bit(8)  | tap_bit(4);
      10: m = tap_bit(9)  | tap_bit(6);
      11: m = tap_bit(10) | tap_bit(8);
      12: m = tap_bit(11) | tap_bit(5)  | tap_bit(3)  | tap_bit(0);
      13: m = tap_bit(12) | tap_bit(3)  | tap_bit(2)  | tap_bit(0);
      14: m = tap_bit(13) | tap_bit(4)  | tap_bit(2)  | tap_bit(0);
      15: m = tap_bit(14) | tap_bit(13);
      16: m = tap_bit(15) | tap_bit(14) | tap_bit(12) | tap_bit(3);
      17: m = tap_bit(16) | tap_bit(13);
      18: m = tap_bit(17) | tap_bit(10);
      19: m = tap_bit(18) | tap_bit(5)  | tap_bit(1)  | tap_bit(0);
      20: m = tap_bit(19) | tap_bit(16);
      21: m = tap_bit(20) | tap_bit(18);
      22: m = tap_bit(21) | tap_bit(20);
      23: m = tap_bit(22) | tap_bit(17);
      24: m = tap_bit(23) | tap_bit(22) | tap_bit(21) | tap_bit(16);
      25: m = tap_bit(24) | tap_bit(21);
      26: m = tap_bit(25) | tap_bit(5)  | tap_bit(1)  | tap_bit(0);
      27: m = tap_bit(26) | tap_bit(4)  | tap_bit(1)  | tap_bit(0);
      28: m = tap_bit(27) | tap_bit(24);
      29: m = tap_bit(28) | tap_bit(26);
      30: m = tap_bit(29) | tap_bit(5)  | tap_bit(3)  | tap_bit(0);
      31: m = tap_bit(30) | tap_bit(27);
      32: m = tap_bit(31) | tap_bit(21) | tap_bit(1)  | tap_bit(0);
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [31:0]  TapMaskFull = tap_mask(N);
  localparam logic [N-1:0] Taps        = TapMaskFull[N-1:0];

  typedef enum logic [1:0] {StIdle, StFill, StValid} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [N-1:0] state_q, state_d;
  logic [N-1:0] ref_q, ref_d;
  logic [W-1:0] data_q, data_d;
  logic         lockup_q, lockup_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] adv;
  logic         step_en;

  // Every tap set has an even number of taps, so the XNOR chain equals the inverted parity.
  always_comb begin
    adv = state_q;
    for (int unsigned i = 0; i < W; i++) begin
      adv = {adv[N-2:0], ~^(adv & Taps)};
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    ref_d    = ref_q;
    data_d   = data_q;
    lockup_d = 1'b0;
    wrap_d   = 1'b0;
    step_en  = 1'b0;
    if (bus.load) begin
      fsm_d = StIdle;
      if (&bus.seed) begin
        state_d  = '0;
        ref_d    = '0;
        lockup_d = 1'b1;
      end else begin
        state_d = bus.seed;
        ref_d   = bus.seed;
      end
    end else begin
      case (fsm_q)
        StIdle:  if (bus.en) fsm_d = StFill;
        StFill: begin
          step_en = 1'b1;
          fsm_d   = StValid;
        end
        StValid: begin
          // Without a handshake the word is held, whatever en does.
          if (bus.ready) begin
            if (bus.en) step_en = 1'b1;
            else        fsm_d   = StIdle;
          end
        end
        default: fsm_d = StIdle;
      endcase
      if (step_en) begin
        state_d = adv;
        data_d  = adv[W-1:0];
        wrap_d  = (adv == ref_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q    <= StIdle;
      state_q  <= '0;
      ref_q    <= '0;
      data_q   <= '0;
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      ref_q    <= ref_d;
      data_q   <= data_d;
      lockup_q <= lockup_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.valid  = (fsm_q == StValid);
  assign bus.data   = data_q;
  assign bus.state  = state_q;
  assign bus.lockup = lockup_q;
  assign bus.wrap   = wrap_q;

endmodule
